tt_um_hoene_frame_sync: RTL
===========================

Name: tt_um_hoene_frame_sync

Overview:
Parametrised framing unit for the smart-LED serial bitstream; it sits between the bit decoder (which supplies data, a bit strobe and an error flag) and the pixel/register shifter.
- Hunts for a configurable sync pattern, then delivers in-frame bits one cycle late.
- Counts bits and words, and flags word and frame boundaries.
- Closes the frame on decoder error, on reaching a word limit, or (optionally) on line-idle timeout.

Parameters:
SYNC_LEN, 2, number of strobed bits in the sync pattern (2..8).
SYNC_PATTERN, 2'b11, pattern to match; MSB is the oldest bit; width SYNC_LEN.
WORD_BITS, 24, bits per word (2..64).
MAX_WORDS, 0, words per frame before DONE; 0 means unlimited.
TIMEOUT_CYCLES, 1024, idle clk cycles without a strobe before the frame is dropped (used only with the optional feature).

Ports:
clk  in  1  global clock
rst_n  in  1  reset, asynchronous assert, active low
in_data  in  1  decoded bit, valid when in_clk=1
in_clk  in  1  bit strobe, single clk cycle per bit
in_error  in  1  decoder error, clears framing
out_frame  out  1  high while in FRAME state
out_data  out  1  last strobed in_data, held between strobes
out_clk  out  1  in_clk delayed one cycle, gated to in-frame bits
out_bit_idx  out  $clog2(WORD_BITS)  index of the bit presented on out_data within its word
out_word_end  out  1  one-cycle pulse with the out_clk of the last bit of a word
out_word_cnt  out  16  completed words in the current frame, saturating at 16'hFFFF
out_frame_end  out  1  one-cycle pulse when FRAME exits for any reason
out_timeout  out  1  one-cycle pulse on an idle timeout

Behaviour:
Reset:
- Async reset drives all outputs to 0 and the state to HUNT; the history register and all counters clear.
- Reset deasserted mid-frame always restarts in HUNT.

Strobe acceptance:
- A strobe is "accepted" when in_clk=1 and in_error=0.

States:
- HUNT:
  - Each accepted strobe shifts in_data into a history register of SYNC_LEN-1 bits and increments a fill count that saturates at SYNC_LEN-1.
  - Match condition: the fill count equals SYNC_LEN-1, and {history, in_data} equals SYNC_PATTERN.
  - On a match: next state is FRAME, out_frame goes to 1 in the next cycle, and the bit index and word count clear.
  - The sync bits are not forwarded; out_clk stays 0 in HUNT.
- FRAME:
  - Each accepted strobe: the next cycle has out_clk=1 and out_data=in_data, with out_bit_idx set to the current bit index. The bit index then increments and wraps from WORD_BITS-1 to 0.
  - On the wrap: out_word_end=1 in the same cycle as out_clk, and out_word_cnt increments.
  - When MAX_WORDS≠0 and the word count reaches MAX_WORDS: next state is DONE, with out_frame_end pulsing 1 and out_frame going to 0, both in the same cycle as the final out_word_end.
- DONE:
  - Strobes are ignored, out_clk stays 0, and out_word_cnt is held.
  - in_error moves the state to HUNT.
  - Only in_error leaves DONE.
- in_error (any state):
  - Next state is HUNT; the history fill count and bit index clear.
  - If the block was in FRAME: out_frame_end pulses and out_frame goes to 0 in the next cycle.
  - out_word_cnt keeps the last frame's value until the next sync match.
  - A partial word is discarded, with no out_word_end.
  - in_error together with in_clk in the same cycle: error wins; the bit is not shifted, matched or counted.

Outputs and boundaries:
- out_data updates only on accepted FRAME strobes; otherwise it holds.
- A sync match on the very strobe that follows an error is legal, provided the history has refilled.
- SYNC_LEN=1 means no history register; a single strobe equal to SYNC_PATTERN matches.
- Latency: input strobe to out_clk is exactly 1 clk.

Optional Feature:
FRAME_SYNC_TIMEOUT_EN:
- When defined: a counter counts clk cycles since the last in_clk, in HUNT and FRAME.
  - Any in_clk clears it.
  - On reaching TIMEOUT_CYCLES-1 with no strobe: out_timeout pulses, and the block acts as if in_error=1 (to HUNT; out_frame_end pulses if the block was in FRAME).
  - In DONE the timeout also returns the block to HUNT.
- When undefined: no counter is built, out_timeout is tied 0, and TIMEOUT_CYCLES is ignored.

Decomposition:
Package tt_um_hoene_frame_sync_pkg holds:
- State encodings: ST_HUNT=2'd0, ST_FRAME=2'd1, ST_DONE=2'd2.
- The WCNT_W=16 constant.
- A clog2 helper function.

Sub-module tt_um_hoene_sync_detect:
- Contains the history shift register, fill counter and pattern compare.
- Inputs: strobe, data, clear. Output: match, combinational from the current bit.

Test Plan:
- Defaults, stream 1,1 then 24 bits of 0xA5C3F0 (MSB first) → out_frame rises 1 clk after the 2nd '1'; 24 out_clk pulses; out_bit_idx 0..23; out_word_end on idx 23; out_word_cnt=1.
- SYNC_LEN=3, SYNC_PATTERN=3'b101, stream 1,1,0,1 → no match on 1,1,0; match on the final 1; out_frame=1.
- MAX_WORDS=2, WORD_BITS=8, sync then 20 bits → out_frame_end pulses with the 2nd out_word_end; last 4 bits produce no out_clk; in_error then sync restarts with out_word_cnt=0 after match.
- Mid-frame, in_error asserted together with in_clk at bit 5 → that bit not forwarded; out_frame_end pulses; state HUNT; out_word_cnt unchanged; new 1,1 resyncs.
- Assert rst_n=0 asynchronously between clk edges mid-frame → all outputs 0 immediately, before the next edge.
- With FRAME_SYNC_TIMEOUT_EN and TIMEOUT_CYCLES=16, sync then silence → out_timeout and out_frame_end pulse 16 clks after the last strobe; without the macro out_frame stays 1.

Source files
------------

// File: rtl/tt_um_hoene_frame_sync_pkg.sv
// Shared types and constants for the smart-LED framing unit.
package tt_um_hoene_frame_sync_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int WCNT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tt_um_hoene_sync_detect.sv
// Sync hunter: history shift register, fill counter and pattern compare.
// match is combinational from the strobed bit so the frame opens on that edge.
module tt_um_hoene_sync_detect
  import tt_um_hoene_frame_sync_pkg::*;
#(
  parameter int                  SYNC_LEN     = 2,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 2'b11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic data,
  input  logic clear,
  output logic match
);

  generate
    if (SYNC_LEN == 1) begin : g_nohist
      logic unused_nohist;
      assign unused_nohist = ^{clk, rst_n, clear};
      assign match = strobe && (data == SYNC_PATTERN[0]);
    end else begin : g_hist
      localparam int HW = SYNC_LEN - 1;
      localparam int FW = clog2(SYNC_LEN);

      logic [HW-1:0]       hist_q, hist_d;
      logic [FW-1:0]       fill_q, fill_d;
      logic [SYNC_LEN-1:0] cat;

      assign cat   = {hist_q, data};
      assign match = strobe && (fill_q == FW'(HW)) && (cat == SYNC_PATTERN);

      always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
          hist_d = '0;
          fill_d = '0;
        end else if (strobe) begin
          hist_d = cat[HW-1:0];
          if (fill_q != FW'(HW)) fill_d = fill_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist_q <= '0;
          fill_q <= '0;
        end else begin
          hist_q <= hist_d;
          fill_q <= fill_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tt_um_hoene_frame_sync.sv
// Framing unit: hunts sync, forwards in-frame bits one clk late, counts words.
// Optional idle timeout is built only when FRAME_SYNC_TIMEOUT_EN is defined.
module tt_um_hoene_frame_sync
  import tt_um_hoene_frame_sync_pkg::*;
#(
  parameter int                  SYNC_LEN       = 2,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN   = 2'b11,
  parameter int                  WORD_BITS      = 24,
  parameter int                  MAX_WORDS      = 0,
  parameter int                  TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_data,
  input  logic                         in_clk,
  input  logic                         in_error,
  output logic                         out_frame,
  output logic                         out_data,
  output logic                         out_clk,
  output logic [$clog2(WORD_BITS)-1:0] out_bit_idx,
  output logic                         out_word_end,
  output logic [15:0]                  out_word_cnt,
  output logic                         out_frame_end,
  output logic                         out_timeout
);

  localparam int            IW       = $clog2(WORD_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BITS - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, oidx_q, oidx_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                data_q, data_d, oclk_q, oclk_d;
  logic                wend_q, wend_d, fend_q, fend_d;
  logic                accept, fstrobe, wrap, match, tmo_hit, abort;

  assign accept  = in_clk && !in_error;
  assign fstrobe = accept && (state_q == ST_FRAME);
  assign wrap    = fstrobe && (idx_q == LAST_IDX);
  assign abort   = in_error || tmo_hit;

  tt_um_hoene_sync_detect #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (accept && (state_q == ST_HUNT)),
    .data   (in_data),
    .clear  (abort || (state_q != ST_HUNT)),
    .match  (match)
  );

`ifdef FRAME_SYNC_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_pulse_q;

  // Restart after firing so an idle line in HUNT does not pulse every cycle.
  assign tmo_hit = !in_clk && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (in_clk || tmo_hit) tmo_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      tmo_pulse_q <= tmo_hit;
    end
  end

  assign out_timeout = tmo_pulse_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit     = 1'b0;
  assign out_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    oclk_d  = 1'b0;
    wend_d  = 1'b0;
    fend_d  = 1'b0;
    if (abort) begin
      state_d = ST_HUNT;
      idx_d   = '0;
      fend_d  = (state_q == ST_FRAME);
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (match) begin
            state_d = ST_FRAME;
            idx_d   = '0;
            wcnt_d  = '0;
          end
        end
        ST_FRAME: begin
          if (fstrobe) begin
            oclk_d = 1'b1;
            data_d = in_data;
            oidx_d = idx_q;
            idx_d  = wrap ? '0 : idx_q + 1'b1;
            if (wrap) begin
              wend_d = 1'b1;
              if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
              if (MAX_WORDS != 0 && (int'(wcnt_q) + 1) == MAX_WORDS) begin
                state_d = ST_DONE;
                fend_d  = 1'b1;
              end
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      idx_q   <= '0;
      oidx_q  <= '0;
      wcnt_q  <= '0;
      data_q  <= 1'b0;
      oclk_q  <= 1'b0;
      wend_q  <= 1'b0;
      fend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      oclk_q  <= oclk_d;
      wend_q  <= wend_d;
      fend_q  <= fend_d;
    end
  end

  assign out_frame     = (state_q == ST_FRAME);
  assign out_data      = data_q;
  assign out_clk       = oclk_q;
  assign out_bit_idx   = oidx_q;
  assign out_word_end  = wend_q;
  assign out_word_cnt  = wcnt_q;
  assign out_frame_end = fend_q;

endmodule
